// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, next-state rule and DR select decode.
// Latency: combinational helpers only. Backpressure: none.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:      n = tms ? TLR    : RTI;
      RTI:      n = tms ? SEL_DR : RTI;
      SEL_DR:   n = tms ? SEL_IR : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR : SH_DR;
      SH_DR:    n = tms ? EX1_DR : SH_DR;
      EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR : SH_DR;
      UPD_DR:   n = tms ? SEL_DR : RTI;
      SEL_IR:   n = tms ? TLR    : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR : SH_IR;
      SH_IR:    n = tms ? EX1_IR : SH_IR;
      EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR : SH_IR;
      UPD_IR:   n = tms ? SEL_DR : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

  // IDCODE wins when both opcodes collide; all-ones and unknown opcodes fall to BYPASS.
  function automatic dr_sel_t dr_decode(input logic [31:0] ir,
                                        input logic [31:0] idcode_op,
                                        input logic [31:0] user_op);
    if (ir == idcode_op) return DR_IDCODE;
    if (ir == user_op)   return DR_USER;
    return DR_BYPASS;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Bare 1149.1 TAP controller: state register plus per-state strobes decoded from it.
// Latency: one rising TCK per transition. Backpressure: none, TMS is taken every edge.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE,
  output logic       tlr,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir
);

  tap_state_t state_q;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) state_q <= TLR;
    else       state_q <= tap_next(state_q, TMS);
  end

  assign STATE  = state_q;
  assign tlr    = (state_q == TLR);
  assign cap_dr = (state_q == CAP_DR);
  assign sh_dr  = (state_q == SH_DR);
  assign upd_dr = (state_q == UPD_DR);
  assign cap_ir = (state_q == CAP_IR);
  assign sh_ir  = (state_q == SH_IR);
  assign upd_ir = (state_q == UPD_IR);

endmodule

// File: rtl/jtag_tap.sv
// TAP with IR, BYPASS, IDCODE and one user DR; shift on rising TCK, TDO/IR/update on falling TCK.
// Latency: first TDO bit half a TCK after entering a shift state. Backpressure: none.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0FFF,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] USER_OP      = IR_WIDTH'(4'b1000),
  parameter int                  USER_WIDTH   = 8
) (
  input  logic                  TCK,
  input  logic                  TRST,
  input  logic                  TMS,
  input  logic                  TDI,
  output logic                  TDO,
  output logic                  TDO_EN,
  output logic [3:0]            STATE,
  output logic [IR_WIDTH-1:0]   IR,
  input  logic [USER_WIDTH-1:0] USER_CAPTURE,
  output logic [USER_WIDTH-1:0] USER_UPDATE,
  output logic                  USER_UPDATE_STB
);

  logic tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .TCK    (TCK),
    .TRST   (TRST),
    .TMS    (TMS),
    .STATE  (STATE),
    .tlr    (tlr),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  logic [IR_WIDTH-1:0]   ir_sr;
  logic                  bypass_sr;
  logic [31:0]           idcode_sr;
  logic [USER_WIDTH-1:0] user_sr;
  dr_sel_t               dr_sel;
  logic                  dr_lsb;

  assign dr_sel = dr_decode(32'(IR), 32'(IDCODE_OP), 32'(USER_OP));

  always_comb begin
    dr_lsb = bypass_sr;
    case (dr_sel)
      DR_IDCODE: dr_lsb = idcode_sr[0];
      DR_USER:   dr_lsb = user_sr[0];
      default:   dr_lsb = bypass_sr;
    endcase
  end

  // Only the selected DR moves; the others keep their contents across scans.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr     <= '0;
      bypass_sr <= 1'b0;
      idcode_sr <= '0;
      user_sr   <= '0;
    end else begin
      if (cap_ir)     ir_sr <= IR_WIDTH'(2'b01);
      else if (sh_ir) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};

      if (cap_dr) begin
        case (dr_sel)
          DR_IDCODE: idcode_sr <= IDCODE_VALUE;
          DR_USER:   user_sr   <= USER_CAPTURE;
          default:   bypass_sr <= 1'b0;
        endcase
      end else if (sh_dr) begin
        case (dr_sel)
          DR_IDCODE: idcode_sr <= {TDI, idcode_sr[31:1]};
          DR_USER:   user_sr   <= (user_sr >> 1) | (USER_WIDTH'(TDI) << (USER_WIDTH - 1));
          default:   bypass_sr <= TDI;
        endcase
      end
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO             <= 1'b0;
      TDO_EN          <= 1'b0;
      IR              <= IDCODE_OP;
      USER_UPDATE     <= '0;
      USER_UPDATE_STB <= 1'b0;
    end else begin
      TDO_EN <= sh_ir | sh_dr;
      TDO    <= sh_ir ? ir_sr[0] : (sh_dr & dr_lsb);

      if (tlr)         IR <= IDCODE_OP;
      else if (upd_ir) IR <= ir_sr;

      USER_UPDATE_STB <= upd_dr && (dr_sel == DR_USER);
      if (upd_dr && (dr_sel == DR_USER)) USER_UPDATE <= user_sr;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Randomised bench for jtag_tap: a queue-based TAP model predicts every falling-edge output,
// and a monitor pops one prediction per falling edge and compares it with the DUT.
module tb_jtag_tap;

  localparam logic [31:0] IDV  = 32'h1000_0FFF;
  localparam logic [3:0]  IDOP = 4'b0001;
  localparam logic [3:0]  UOP  = 4'b1000;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                         S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0,
                         S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA,
                         S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  logic       TCK, TRST, TMS, TDI, TDO, TDO_EN, USER_UPDATE_STB;
  logic [3:0] STATE, IR;
  logic [7:0] USER_CAPTURE, USER_UPDATE;

  jtag_tap #(
    .IR_WIDTH(4), .IDCODE_VALUE(IDV), .IDCODE_OP(IDOP), .USER_OP(UOP), .USER_WIDTH(8)
  ) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .STATE(STATE), .IR(IR), .USER_CAPTURE(USER_CAPTURE), .USER_UPDATE(USER_UPDATE),
    .USER_UPDATE_STB(USER_UPDATE_STB)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  typedef struct packed {
    logic       en;
    logic       tdo;
    logic [3:0] st;
    logic [3:0] ir;
    logic [7:0] uu;
    logic       stb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [3:0] m_st, m_ir;
  logic [7:0] m_uu;
  logic       ir_q[$];
  logic       dr_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  function automatic void set_nx(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nx0[s] = on0;
    nx1[s] = on1;
  endfunction

  // One TCK period: drive, advance the model at the rising edge, queue the falling-edge prediction.
  task automatic step(input logic tms, input logic tdi);
    exp_t e;
    logic stb;
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    stb = 1'b0;
    if (!TRST) begin
      m_st = S_TLR; m_ir = IDOP; m_uu = 8'h00;
      ir_q = {}; dr_q = {};
    end else begin
      if (m_st == S_CIR) begin
        ir_q = {};
        for (int i = 0; i < 4; i++) ir_q.push_back(i == 0);
      end else if (m_st == S_CDR) begin
        dr_q = {};
        if (m_ir == IDOP)     for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
        else if (m_ir == UOP) for (int i = 0; i < 8; i++)  dr_q.push_back(USER_CAPTURE[i]);
        else                  dr_q.push_back(1'b0);
      end else if (m_st == S_SHIR) begin
        ir_q.push_back(tdi);
        void'(ir_q.pop_front());
      end else if (m_st == S_SHDR) begin
        dr_q.push_back(tdi);
        void'(dr_q.pop_front());
      end
      m_st = tms ? nx1[m_st] : nx0[m_st];
      if (m_st == S_UIR) m_ir = 4'(pack(ir_q));
      if (m_st == S_TLR) m_ir = IDOP;
      if (m_st == S_UDR && m_ir == UOP) begin
        m_uu = 8'(pack(dr_q));
        stb  = 1'b1;
      end
    end
    e.st  = m_st;
    e.en  = (m_st == S_SHIR) || (m_st == S_SHDR);
    e.tdo = (m_st == S_SHIR) ? ir_q[0] : (m_st == S_SHDR) ? dr_q[0] : 1'b0;
    e.ir  = m_ir;
    e.uu  = m_uu;
    e.stb = stb;
    exp_q.push_back(e);
    @(negedge TCK);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge TCK);
      #1;
      if (TDO_EN === 1'b1) en_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", STATE, e.st);
        chk("tdo_en", TDO_EN, e.en);
        chk("tdo", TDO, e.tdo);
        chk("ir", IR, e.ir);
        chk("user_update", USER_UPDATE, e.uu);
        chk("user_stb", USER_UPDATE_STB, e.stb);
      end else if (TDO_EN !== 1'b0) begin
        chk("idle_tdo_en", TDO_EN, 0);
      end
    end
  end

  task automatic scan_ir(input logic [3:0] v);
    int c0 = en_cnt;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 0); step(0, 0);
    chk("ir_en_bits", en_cnt, c0 + 4);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at);
    int c0 = en_cnt;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) || (i == pause_at), din[i]);
      if (i == pause_at && i < n - 1) begin
        step(0, 1); step(0, 0); step(0, 1);
        step(1, 0); step(0, 0);
      end
    end
    step(1, 0); step(0, 0);
    chk("dr_en_bits", en_cnt, c0 + n);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0]  op;
    logic [63:0] din;
    int          n, pa, r;

    set_nx(S_TLR, S_RTI, S_TLR);   set_nx(S_RTI, S_RTI, S_SDR);
    set_nx(S_SDR, S_CDR, S_SIR);   set_nx(S_SIR, S_CIR, S_TLR);
    set_nx(S_CDR, S_SHDR, S_E1DR); set_nx(S_SHDR, S_SHDR, S_E1DR);
    set_nx(S_E1DR, S_PDR, S_UDR);  set_nx(S_PDR, S_PDR, S_E2DR);
    set_nx(S_E2DR, S_SHDR, S_UDR); set_nx(S_UDR, S_RTI, S_SDR);
    set_nx(S_CIR, S_SHIR, S_E1IR); set_nx(S_SHIR, S_SHIR, S_E1IR);
    set_nx(S_E1IR, S_PIR, S_UIR);  set_nx(S_PIR, S_PIR, S_E2IR);
    set_nx(S_E2IR, S_SHIR, S_UIR); set_nx(S_UIR, S_RTI, S_SDR);

    m_st = S_TLR; m_ir = IDOP; m_uu = 8'h00;
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; USER_CAPTURE = 8'h00;
    #1 TRST = 1'b0;
    #1;
    chk("rst_state", STATE, S_TLR);
    chk("rst_ir", IR, IDOP);
    chk("rst_tdo_en", TDO_EN, 0);
    chk("rst_user_update", USER_UPDATE, 0);
    @(negedge TCK);
    #2;
    step(1, 0); step(0, 0);
    TRST = 1'b1;
    step(0, 0);

    // IDCODE read straight out of reset
    scan_dr(32, 64'h0, -1);

    // BYPASS via all-ones opcode: one-bit delay on the DR path
    scan_ir(4'hF);
    chk("bypass_ir", IR, 4'hF);
    scan_dr(5, 64'h0D, -1);

    // user DR capture/update
    scan_ir(UOP);
    USER_CAPTURE = 8'hA5;
    scan_dr(8, 64'h3C, -1);
    chk("user_update_3c", USER_UPDATE, 8'h3C);

    // pause mid-shift, then resume
    USER_CAPTURE = 8'h96;
    scan_dr(8, 64'hE1, 3);
    chk("user_update_e1", USER_UPDATE, 8'hE1);

    // TMS-only reset from PauseDR
    step(1, 0); step(0, 0); step(0, 0); step(1, 1); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms_rst_state", STATE, S_TLR);
    chk("tms_rst_ir", IR, IDOP);
    step(0, 0);

    // TRST mid user-DR shift aborts at once and clears the update latch
    scan_ir(UOP);
    USER_CAPTURE = 8'h5A;
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 1); step(0, 0);
    chk("pre_abort_tdo_en", TDO_EN, 1);
    TRST = 1'b0;
    #1;
    chk("abort_state", STATE, S_TLR);
    chk("abort_ir", IR, IDOP);
    chk("abort_tdo_en", TDO_EN, 0);
    chk("abort_user_update", USER_UPDATE, 0);
    chk("abort_stb", USER_UPDATE_STB, 0);
    #1;
    step(1, 1);
    TRST = 1'b1;
    step(0, 0);

    for (int k = 0; k < 25; k++) begin
      r  = $urandom_range(0, 3);
      op = (r == 0) ? IDOP : (r == 1) ? UOP : (r == 2) ? 4'hF : 4'($urandom);
      scan_ir(op);
      USER_CAPTURE = 8'($urandom);
      n   = $urandom_range(1, 40);
      din = {$urandom, $urandom};
      pa  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      scan_dr(n, din, pa);
    end

    for (int k = 0; k < 400; k++) begin
      if (k % 16 == 0) USER_CAPTURE = 8'($urandom);
      step($urandom_range(0, 9) < 4, 1'($urandom));
    end

    step(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
